// File: rtl/ram_copy_engine_pkg.sv
// Shared definitions for the RAM copy engine: FSM encoding, default sizes
// and the maximum job length helper.
package ram_copy_engine_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_RD_LAT = 1;

  // Engine FSM states; encodings are fixed so debug dumps stay readable.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // Largest accepted word count: one full pass over the address space.
  function automatic int max_len(input int addr_w);
    return 32'sd1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_copy_engine_if.sv
// Control and RAM-port bundle for the copy engine. The master side is the
// engine itself; the slave side is the control path plus the RAM.
interface ram_copy_engine_if
  import ram_copy_engine_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  // Job request and status
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_done;

  // Single-port RAM connection
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    input  start, src_addr, dst_addr, len, ram_rdata,
    output busy, done, err, words_done, ram_addr, ram_wdata, ram_we
  );

  modport slave (
    output start, src_addr, dst_addr, len, ram_rdata,
    input  busy, done, err, words_done, ram_addr, ram_wdata, ram_we
  );

endinterface

// File: rtl/ram_copy_engine.sv
// Autonomous word mover: on start, copies len words from src_addr to
// dst_addr through a single-port RAM, strictly ascending, one read then one
// write per word. All outputs are registered and computed from next state.
module ram_copy_engine
  import ram_copy_engine_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic               clk,
  input  logic               rst,
  ram_copy_engine_if.master  bus
);

  localparam int LAT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  localparam logic [ADDR_W:0]   MAX_LEN  = (ADDR_W + 1)'(max_len(ADDR_W));
  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W - 1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DAT_ZERO = {DATA_W{1'b0}};
  localparam logic [LAT_W-1:0]  LAT_ZERO = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0]  LAT_ONE  = {{(LAT_W - 1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT);

  // FSM state
  state_e state_q, state_d;

  // Job datapath: pointers, remaining count, read-latency counter
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [ADDR_W-1:0] dp_q, dp_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W:0]   wd_q, wd_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              err_flag_q, err_flag_d;

  // Registered outputs; ram_wdata_q doubles as the read data buffer
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic len_bad_s;
  logic len_zero_s;
  logic rd_last_s;

  assign len_bad_s  = (bus.len > MAX_LEN);
  assign len_zero_s = (bus.len == CNT_ZERO);
  assign rd_last_s  = (state_q == ST_RD) && (lat_q == LAT_LAST);

  // State register; reset abandons any job in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is honoured only in IDLE, everything else ignores it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (len_bad_s || len_zero_s) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (rd_last_s) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_WR: begin
        if (rem_q == CNT_ONE) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: latch the job in IDLE, advance pointers on each write
  always_comb begin
    sp_d       = sp_q;
    dp_d       = dp_q;
    rem_d      = rem_q;
    wd_d       = wd_q;
    err_flag_d = err_flag_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sp_d       = bus.src_addr;
          dp_d       = bus.dst_addr;
          rem_d      = bus.len;
          wd_d       = CNT_ZERO;
          err_flag_d = len_bad_s;
        end else begin
          err_flag_d = err_flag_q;
        end
      end
      ST_WR: begin
        sp_d  = sp_q + PTR_ONE;
        dp_d  = dp_q + PTR_ONE;
        rem_d = rem_q - CNT_ONE;
        wd_d  = wd_q + CNT_ONE;
      end
      default: begin
        sp_d = sp_q;
      end
    endcase

    // Latency counter restarts on every entry into RD
    if ((state_q == ST_RD) && (state_d == ST_RD)) begin
      lat_d = lat_q + LAT_ONE;
    end else begin
      lat_d = LAT_ZERO;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q       <= PTR_ZERO;
      dp_q       <= PTR_ZERO;
      rem_q      <= CNT_ZERO;
      wd_q       <= CNT_ZERO;
      lat_q      <= LAT_ZERO;
      err_flag_q <= 1'b0;
    end else begin
      sp_q       <= sp_d;
      dp_q       <= dp_d;
      rem_q      <= rem_d;
      wd_q       <= wd_d;
      lat_q      <= lat_d;
      err_flag_q <= err_flag_d;
    end
  end

  // Output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    busy_d     = (state_d == ST_RD) || (state_d == ST_WR);
    done_d     = (state_d == ST_FIN);
    err_d      = (state_d == ST_FIN) && err_flag_d;
    ram_we_d   = (state_d == ST_WR);
    ram_addr_d = ram_addr_q;
    case (state_d)
      ST_RD:   ram_addr_d = sp_d;
      ST_WR:   ram_addr_d = dp_d;
      default: ram_addr_d = ram_addr_q;
    endcase
    if (rd_last_s) begin
      ram_wdata_d = bus.ram_rdata;
    end else begin
      ram_wdata_d = ram_wdata_q;
    end
  end

  // Output registers; ram_we falls the moment reset asserts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= PTR_ZERO;
      ram_wdata_q <= DAT_ZERO;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.words_done = wd_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Scoreboard bench for ram_copy_engine: one RD_LAT=1 and one RD_LAT=0
// instance, each with its own behavioural RAM. Stimulus pushes expected
// writes, done pulses and memory contents; one monitor pops and compares.
module tb_ram_copy_engine;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wexp_t;

  typedef struct packed {
    int         cyc;
    logic       err;
    logic [8:0] wd;
  } dexp_t;

  typedef struct packed {
    int          k;
    logic [7:0]  addr;
    logic [31:0] data;
  } mexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = 8'd0;
  logic [31:0] pre_data = 32'd0;

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  logic [31:0] rd1_q;
  logic [31:0] exp_mem [2][256];

  wexp_t wq [2][$];
  dexp_t dq [2][$];
  mexp_t mq [$];

  ram_copy_engine_if #(.DATA_W(32), .ADDR_W(8)) b0 ();
  ram_copy_engine_if #(.DATA_W(32), .ADDR_W(8)) b1 ();

  ram_copy_engine #(.DATA_W(32), .ADDR_W(8), .RD_LAT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  ram_copy_engine #(.DATA_W(32), .ADDR_W(8), .RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAMs: mem1 has a registered read, mem0 a combinational one
  always @(posedge clk) begin
    if (pre_we) begin
      mem0[pre_addr] <= pre_data;
      mem1[pre_addr] <= pre_data;
    end else begin
      if (b0.ram_we) mem0[b0.ram_addr] <= b0.ram_wdata;
      if (b1.ram_we) mem1[b1.ram_addr] <= b1.ram_wdata;
    end
    rd1_q <= mem1[b1.ram_addr];
  end
  assign b1.ram_rdata = rd1_q;
  assign b0.ram_rdata = mem0[b0.ram_addr];

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h (cycle %0d)", name, k, act, exp, cyc);
    end
  endtask

  task automatic mon(input int k, input logic busy, input logic done, input logic err,
                     input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                     input logic [8:0] wd);
    wexp_t w;
    dexp_t d;
    if (rst) begin
      chk("reset_state", k, {11'd0, busy, done, err, we, addr, wdata, wd}, 64'd0);
    end else begin
      if (we) begin
        if (wq[k].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write dut%0d: got addr %h data %h want no write", k, addr, wdata);
        end else begin
          w = wq[k].pop_front();
          chk("write", k, {23'd0, busy, addr, wdata}, {23'd0, 1'b1, w.addr, w.data});
        end
      end
      if (dq[k].size() > 0 && cyc == dq[k][0].cyc) begin
        d = dq[k].pop_front();
        chk("done", k, {52'd0, done, err, busy, wd}, {52'd0, 1'b1, d.err, 1'b0, d.wd});
      end else if (done) begin
        total++;
        bad++;
        $display("FAIL spurious_done dut%0d: got done=1 want 0 (cycle %0d)", k, cyc);
      end
    end
  endtask

  // Monitor: the only place comparisons are made
  always @(negedge clk) begin
    mexp_t m;
    logic [31:0] act;
    mon(0, b0.busy, b0.done, b0.err, b0.ram_we, b0.ram_addr, b0.ram_wdata, b0.words_done);
    mon(1, b1.busy, b1.done, b1.err, b1.ram_we, b1.ram_addr, b1.ram_wdata, b1.words_done);
    if (mq.size() > 0) begin
      m = mq.pop_front();
      act = (m.k == 1) ? mem1[m.addr] : mem0[m.addr];
      chk("mem", m.k, {24'd0, m.addr, act}, {24'd0, m.addr, m.data});
    end
  end

  task automatic set_start(input int k, input logic s, input logic [7:0] src,
                           input logic [7:0] dst, input logic [8:0] len);
    if (k == 1) begin
      b1.start = s; b1.src_addr = src; b1.dst_addr = dst; b1.len = len;
    end else begin
      b0.start = s; b0.src_addr = src; b0.dst_addr = dst; b0.len = len;
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    exp_mem[0][a] = d;
    exp_mem[1][a] = d;
  endtask

  // Issue one start pulse and queue everything the job should produce
  task automatic issue_job(input int k, input logic [7:0] src, input logic [7:0] dst,
                           input logic [8:0] len, output int dcyc);
    int lat;
    logic [7:0] sa, da;
    logic [31:0] d;
    lat = (k == 1) ? 1 : 0;
    @(negedge clk);
    if (len > 9'd256) begin
      dcyc = cyc + 1;
      dq[k].push_back('{dcyc, 1'b1, 9'd0});
    end else if (len == 9'd0) begin
      dcyc = cyc + 1;
      dq[k].push_back('{dcyc, 1'b0, 9'd0});
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        sa = src + 8'(i);
        da = dst + 8'(i);
        d  = exp_mem[k][sa];
        wq[k].push_back('{da, d});
        exp_mem[k][da] = d;
      end
      dcyc = cyc + 1 + int'(len) * (lat + 2);
      dq[k].push_back('{dcyc, 1'b0, len});
    end
    set_start(k, 1'b1, src, dst, len);
    @(negedge clk);
    set_start(k, 1'b0, 8'd0, 8'd0, 9'd0);
  endtask

  task automatic wait_done(input int k);
    for (int i = 0; i < 2000 && dq[k].size() > 0; i++) @(negedge clk);
  endtask

  task automatic mem_expect(input int k, input logic [7:0] a, input logic [31:0] d);
    mq.push_back('{k, a, d});
  endtask

  task automatic wait_mem();
    for (int i = 0; i < 100 && mq.size() > 0; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    set_start(0, 1'b0, 8'd0, 8'd0, 9'd0);
    set_start(1, 1'b0, 8'd0, 8'd0, 9'd0);

    // Fill both RAMs under reset; reset state is checked every cycle meanwhile
    for (int i = 0; i < 256; i++) preload(8'(i), 32'hC0DE_0000 | 32'(i));
    preload(8'h10, 32'h1234_5678);
    preload(8'h11, 32'hABCD_EF01);
    preload(8'h12, 32'hDEAD_BEEF);
    preload(8'h13, 32'h0000_0001);
    preload(8'h20, 32'h0000_000A);
    preload(8'h21, 32'h0000_000B);
    preload(8'h22, 32'h0000_000C);
    @(negedge clk);
    pre_we = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic copy, RD_LAT=1: done 13 cycles after start
    issue_job(1, 8'h10, 8'h40, 9'd4, dc);
    wait_done(1);
    mem_expect(1, 8'h40, 32'h1234_5678);
    mem_expect(1, 8'h41, 32'hABCD_EF01);
    mem_expect(1, 8'h42, 32'hDEAD_BEEF);
    mem_expect(1, 8'h43, 32'h0000_0001);
    wait_mem();

    // Address wrap on the source side
    issue_job(1, 8'hFE, 8'h02, 9'd4, dc);
    wait_done(1);
    mem_expect(1, 8'h02, 32'hC0DE_00FE);
    mem_expect(1, 8'h03, 32'hC0DE_00FF);
    mem_expect(1, 8'h04, 32'hC0DE_0000);
    mem_expect(1, 8'h05, 32'hC0DE_0001);
    wait_mem();

    // Boundary lengths
    issue_job(1, 8'h10, 8'h50, 9'd0, dc);
    wait_done(1);
    issue_job(1, 8'h10, 8'h50, 9'd257, dc);
    wait_done(1);
    mem_expect(1, 8'h50, 32'hC0DE_0050);
    wait_mem();
    issue_job(1, 8'h00, 8'h00, 9'd256, dc);
    wait_done(1);
    mem_expect(1, 8'h40, 32'h1234_5678);
    mem_expect(1, 8'hFF, 32'hC0DE_00FF);
    wait_mem();

    // Overlapping ranges replicate the first source word
    issue_job(1, 8'h20, 8'h21, 9'd2, dc);
    wait_done(1);
    mem_expect(1, 8'h20, 32'h0000_000A);
    mem_expect(1, 8'h21, 32'h0000_000A);
    mem_expect(1, 8'h22, 32'h0000_000A);
    wait_mem();

    // Starts while busy and during FIN are ignored
    issue_job(1, 8'h60, 8'h80, 9'd8, dc);
    repeat (5) @(negedge clk);
    set_start(1, 1'b1, 8'h00, 8'h90, 9'd3);
    @(negedge clk);
    set_start(1, 1'b0, 8'd0, 8'd0, 9'd0);
    for (int i = 0; i < 100 && cyc < dc; i++) @(negedge clk);
    set_start(1, 1'b1, 8'h00, 8'h90, 9'd3);
    @(negedge clk);
    set_start(1, 1'b0, 8'd0, 8'd0, 9'd0);
    repeat (10) @(negedge clk);
    mem_expect(1, 8'h80, 32'hC0DE_0060);
    mem_expect(1, 8'h87, 32'hC0DE_0067);
    mem_expect(1, 8'h90, 32'hC0DE_0090);
    wait_mem();

    // Reset in the first WR cycle: that write must never land
    issue_job(1, 8'h10, 8'hA0, 9'd4, dc);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (b1.ram_we) break;
    end
    rst = 1'b1;
    wq[1].delete();
    dq[1].delete();
    for (int i = 0; i < 4; i++) exp_mem[1][8'hA0 + 8'(i)] = 32'hC0DE_00A0 + 32'(i);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mem_expect(1, 8'hA0, 32'hC0DE_00A0);
    wait_mem();

    // Engine back in IDLE: a one-word job completes in 4 cycles
    issue_job(1, 8'h13, 8'hB0, 9'd1, dc);
    wait_done(1);
    mem_expect(1, 8'hB0, 32'h0000_0001);
    wait_mem();

    // RD_LAT=0 build: done 9 cycles after start, same memory result
    issue_job(0, 8'h10, 8'h40, 9'd4, dc);
    wait_done(0);
    mem_expect(0, 8'h40, 32'h1234_5678);
    mem_expect(0, 8'h41, 32'hABCD_EF01);
    mem_expect(0, 8'h42, 32'hDEAD_BEEF);
    mem_expect(0, 8'h43, 32'h0000_0001);
    wait_mem();

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
